// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the MIPS execution ALU. Holds the 4-bit
//               operation codes produced by ALU control and the state
//               encoding of the execution unit's controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation codes, shared with ALU control
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MULTU = 4'b1000;

    // Controller state encoding
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_mul  = 1'b1;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/multu_seq.sv
`default_nettype none
// ============================================================================
// Module      : multu_seq
// Description : Iterative unsigned shift-add multiplier core. One iteration
//               per step edge; WIDTH iterations form the full product.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   start        in   latch operands, clear accumulator, load count
//   step         in   perform one shift-add iteration
//   multiplicand in   WIDTH-bit operand latched on start
//   multiplier   in   WIDTH-bit operand latched on start
//   done         out  high during the step that completes the product
//   product      out  accumulator value after the current iteration; equals
//                     the full 2*WIDTH-bit product while done is high
// Revision    : 1.0 - initial release
// ============================================================================
module multu_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;

    // Add into the upper half keeping the carry, then shift the
    // {carry, accumulator} pair right by one; the lowest bit falls off.
    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

    // The iteration that takes count from 1 to 0 is the last one, so its
    // combinational result is already the final product.
    assign done    = step && (r_count == CW'(1));
    assign product = w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (start) begin
            r_mcand  <= multiplicand;
            r_mplier <= multiplier;
            r_acc    <= '0;
            r_count  <= CW'(WIDTH);
        end else if (step) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CW'(1);
        end
    end

endmodule : multu_seq
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Registered execution ALU. Single-cycle ops return one cycle
//               after issue; MULTU runs WIDTH iterations in multu_seq and
//               writes HI/LO on completion.
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   in_valid    in   operation issued this cycle (ignored while busy)
//   Alu_Signal  in   4-bit op code from ALU control
//   A, B        in   WIDTH-bit operands
//   busy        out  multiply in progress
//   out_valid   out  one-cycle pulse, result/zero valid
//   result      out  registered result (LO for MULTU)
//   zero        out  result == 0, registered with result
//   hi, lo      out  product words of the last completed MULTU
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       Alu_Signal,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [0:0]         r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_start;
    logic               w_step;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_alu;
    logic               w_slt;

    assign w_accept = in_valid && (r_state == c_st_idle);
    assign w_start  = w_accept && (Alu_Signal == ALU_MULTU);
    assign w_step   = (r_state == c_st_mul);

    assign w_slt = $signed(A) < $signed(B);

    // Unlisted codes fall through to zero so the datapath still gets a
    // response and never stalls.
    always_comb begin
        w_alu = '0;
        case (Alu_Signal)
            ALU_AND: w_alu = A & B;
            ALU_OR:  w_alu = A | B;
            ALU_ADD: w_alu = A + B;
            ALU_SUB: w_alu = A - B;
            ALU_SLT: w_alu = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_NOR: w_alu = ~(A | B);
            default: w_alu = '0;
        endcase
    end

    multu_seq #(
        .WIDTH        (WIDTH)
    ) u_multu_seq (
        .clk          (clk),
        .rst          (rst),
        .start        (w_start),
        .step         (w_step),
        .multiplicand (A),
        .multiplier   (B),
        .done         (w_mul_done),
        .product      (w_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_state <= c_st_mul;
                    end else if (w_accept) begin
                        r_result    <= w_alu;
                        r_zero      <= (w_alu == '0);
                        r_out_valid <= 1'b1;
                    end
                end
                c_st_mul: begin
                    if (w_mul_done) begin
                        r_hi        <= w_product[2*WIDTH-1:WIDTH];
                        r_lo        <= w_product[WIDTH-1:0];
                        r_result    <= w_product[WIDTH-1:0];
                        r_zero      <= (w_product[WIDTH-1:0] == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // busy comes straight from the state register, never from in_valid
    assign busy      = (r_state == c_st_mul);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit with directed and
//               randomized operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [3:0]   Alu_Signal;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .Alu_Signal (Alu_Signal),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .out_valid  (out_valid),
        .result     (result),
        .zero       (zero),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result of a single-cycle op from plain arithmetic
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return W'(a + b);
            4'b0110: return W'(a - b);
            4'b0111: return (sa < sb) ? W'(1) : W'(0);
            4'b1100: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one single-cycle op; in_valid is left high so calls chain
    // back-to-back, one per cycle.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        logic [W-1:0] e;
        e = ref_alu(op, a, b);
        in_valid   = 1'b1;
        Alu_Signal = op;
        A          = a;
        B          = b;
        tick();
        check("op_valid", W'(out_valid), W'(1));
        check("op_result", result, e);
        check("op_zero", W'(zero), W'(e == '0));
        check("op_busy", W'(busy), W'(0));
        check("op_hi", hi, exp_hi);
        check("op_lo", lo, exp_lo);
    endtask

    // Full MULTU; optionally fires add pulses while busy, which must vanish.
    // Returns in the completion cycle.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit inject);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        in_valid   = 1'b1;
        Alu_Signal = 4'b1000;
        A          = a;
        B          = b;
        tick();
        for (int i = 0; i < W; i++) begin
            if (i > 0) tick();
            check("mul_busy", W'(busy), W'(1));
            check("mul_no_valid", W'(out_valid), W'(0));
            in_valid   = inject ? W'(i) % 2 == 0 : 1'b0;
            Alu_Signal = 4'b0010;
            A          = W'(i);
            B          = W'(1);
        end
        in_valid = 1'b0;
        tick();
        exp_hi = p[2*W-1:W];
        exp_lo = p[W-1:0];
        check("mul_done_valid", W'(out_valid), W'(1));
        check("mul_done_busy", W'(busy), W'(0));
        check("mul_hi", hi, exp_hi);
        check("mul_lo", lo, exp_lo);
        check("mul_result", result, exp_lo);
        check("mul_zero", W'(zero), W'(exp_lo == '0));
    endtask

    task automatic idle_check(input string tag);
        in_valid = 1'b0;
        tick();
        check(tag, W'(out_valid), W'(0));
    endtask

    initial begin
        logic [3:0] codes [9];
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                  4'b1100, 4'b1000, 4'b1111, 4'b0011};
        rst = 1'b1; in_valid = 1'b0; Alu_Signal = '0; A = '0; B = '0;

        // Reset state
        tick(); tick();
        check("rst_busy", W'(busy), W'(0));
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_result", result, W'(0));
        check("rst_zero", W'(zero), W'(0));
        check("rst_hi", hi, W'(0));
        check("rst_lo", lo, W'(0));
        rst = 1'b0;
        idle_check("idle_valid0");
        idle_check("idle_valid1");

        // Back-to-back single ops
        issue(4'b0010, 32'd5, 32'd7);
        check("add_5_7", result, 32'd12);
        issue(4'b0110, 32'd7, 32'd7);
        check("sub_zero", W'(zero), W'(1));
        issue(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        check("and_val", result, 32'h00F0_00F0);
        issue(4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        check("or_val", result, 32'hFFF0_FFF0);
        issue(4'b1100, 32'h0, 32'h0);
        check("nor_val", result, 32'hFFFF_FFFF);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg", result, 32'd1);
        issue(4'b0111, 32'd1, 32'hFFFF_FFFF);
        check("slt_pos", result, 32'd0);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
        check("add_wrap_zero", W'(zero), W'(1));
        idle_check("single_no_repeat");

        // MULTU with ignored issues while busy, then add in completion cycle
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("big_hi", hi, 32'hFFFF_FFFE);
        check("big_lo", lo, 32'h0000_0001);
        issue(4'b0010, 32'd100, 32'd23);
        check("post_mul_add", result, 32'd123);
        idle_check("post_mul_idle");

        // Reset in the middle of a MULTU 3x4
        in_valid = 1'b1; Alu_Signal = 4'b1000; A = 32'd3; B = 32'd4;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("mid_busy", W'(busy), W'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("abort_busy", W'(busy), W'(0));
        check("abort_valid", W'(out_valid), W'(0));
        check("abort_hi", hi, W'(0));
        check("abort_lo", lo, W'(0));
        for (int i = 0; i < W; i++) begin
            tick();
            check("abort_no_pulse", W'(out_valid), W'(0));
        end

        // Fresh MULTU 3x4
        do_mul(32'd3, 32'd4, 1'b0);
        check("mul12_lo", lo, 32'd12);
        check("mul12_hi", hi, 32'd0);
        idle_check("mul12_single_pulse");

        // Unlisted code leaves hi/lo alone
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        check("unlisted_zero", W'(zero), W'(1));
        idle_check("unlisted_idle");

        // Reset and issue together: the op is lost
        rst = 1'b1; in_valid = 1'b1; Alu_Signal = 4'b0001;
        A = 32'hFF; B = 32'h1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check("rst_wins_valid", W'(out_valid), W'(0));
        check("rst_wins_result", result, W'(0));
        idle_check("rst_wins_idle");

        // Randomized ops against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [3:0]   op;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            op = codes[$urandom_range(8, 0)];
            ra = $urandom();
            rb = ($urandom_range(3, 0) == 0) ? ra : W'($urandom());
            if (op == 4'b1000) begin
                do_mul(ra, rb, $urandom_range(1, 0) == 1);
                in_valid = 1'b0;
            end else begin
                issue(op, ra, rb);
            end
        end
        idle_check("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire
